// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
//
// Purpose:
//   Consumer end of the ALU flag interface of the 16-bit core. Holds the
//   architectural SZCV flag register, accepts branch requests from decode,
//   resolves them taken/not-taken against forwarded or stored flags, and
//   returns the next PC to fetch over a valid/ready handshake.
//
// Configuration:
//   BRANCH_STATS_EN  - when defined, adds saturating taken/not-taken counters
//                      (stat_taken, stat_not_taken) and a synchronous clear
//                      input (stat_clr).
//
// Parameters:
//   PC_W   width of PC, branch target and next-PC values
//   CNT_W  width of statistics counters (BRANCH_STATS_EN only)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flag_we         ALU writes szcv_in into the flag register this cycle
//   szcv_in[3:0]    ALU flags {S,Z,C,V}
//   flags_pending   a flag-writing ALU op is in flight
//   br_valid/ready  branch request handshake from decode
//   br_cond[2:0]    condition code
//   br_target       taken target PC
//   pc_plus1        fall-through PC
//   res_valid/ready resolution handshake towards fetch
//   res_taken       branch taken
//   res_pc          next PC
//   flags_out[3:0]  current flag register {S,Z,C,V}
//   stat_*          statistics (BRANCH_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_cond_unit #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flag_we,
    input  logic [3:0]      szcv_in,
    input  logic            flags_pending,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] pc_plus1,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [PC_W-1:0] res_pc,
    output logic [3:0]      flags_out
`ifdef BRANCH_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_not_taken
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Condition codes
    localparam logic [2:0] C_BE  = 3'b000;
    localparam logic [2:0] C_BLT = 3'b001;
    localparam logic [2:0] C_BLE = 3'b010;
    localparam logic [2:0] C_BNE = 3'b011;
    localparam logic [2:0] C_B   = 3'b100;
    localparam logic [2:0] C_BC  = 3'b101;
    localparam logic [2:0] C_BNC = 3'b110;

    state_t          r_state;
    logic [3:0]      r_flags;
    logic [2:0]      r_cond;
    logic [PC_W-1:0] r_target;
    logic [PC_W-1:0] r_pc_plus1;
    logic            r_res_taken;
    logic [PC_W-1:0] r_res_pc;

    state_t          w_next_state;
    logic            w_capture;     // park request while flags are in flight
    logic            w_load_res;    // evaluate and register a resolution
    logic [2:0]      w_eval_cond;
    logic [PC_W-1:0] w_eval_target;
    logic [PC_W-1:0] w_eval_pc;
    logic [3:0]      w_flags;
    logic            w_taken;
    logic            w_accept;

    // f = {S,Z,C,V}
    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] f);
        logic s, z, c, v;
        {s, z, c, v} = f;
        case (cond)
            C_BE:    cond_met = z;
            C_BLT:   cond_met = s ^ v;
            C_BLE:   cond_met = z | (s ^ v);
            C_BNE:   cond_met = ~z;
            C_B:     cond_met = 1'b1;
            C_BC:    cond_met = c;
            C_BNC:   cond_met = ~c;
            default: cond_met = 1'b0;   // reserved: never taken
        endcase
    endfunction

    // A flag write in the evaluation cycle is forwarded ahead of the register.
    assign w_flags = flag_we ? szcv_in : r_flags;

    // Next-state and control decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_next_state  = r_state;
        w_capture     = 1'b0;
        w_load_res    = 1'b0;
        w_eval_cond   = br_cond;
        w_eval_target = br_target;
        w_eval_pc     = pc_plus1;
        br_ready      = 1'b0;

        case (r_state)
            S_IDLE: begin
                br_ready = 1'b1;
            end
            S_WAIT: begin
                // Resolve from the parked request once flags land, or once the
                // pending op turns out not to write them after all.
                if (flag_we || !flags_pending) begin
                    w_eval_cond   = r_cond;
                    w_eval_target = r_target;
                    w_eval_pc     = r_pc_plus1;
                    w_load_res    = 1'b1;
                    w_next_state  = S_RESP;
                end
            end
            S_RESP: begin
                // A consumed response frees the slot in the same cycle.
                br_ready = res_ready;
                if (res_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // A new request is handled identically from IDLE or from a completing
        // RESP, giving one resolution per cycle back-to-back.
        if (w_accept) begin
            if (flags_pending && !flag_we) begin
                w_capture    = 1'b1;
                w_next_state = S_WAIT;
            end else begin
                w_load_res   = 1'b1;
                w_next_state = S_RESP;
            end
        end
    end

    assign w_accept = br_valid && br_ready;
    assign w_taken  = cond_met(w_eval_cond, w_flags);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flag register: written whenever the ALU says so, in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else if (flag_we) begin
            r_flags <= szcv_in;
        end
    end

    // Parked request and registered resolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cond      <= 3'b000;
            r_target    <= '0;
            r_pc_plus1  <= '0;
            r_res_taken <= 1'b0;
            r_res_pc    <= '0;
        end else begin
            if (w_capture) begin
                r_cond     <= br_cond;
                r_target   <= br_target;
                r_pc_plus1 <= pc_plus1;
            end
            if (w_load_res) begin
                r_res_taken <= w_taken;
                r_res_pc    <= w_taken ? w_eval_target : w_eval_pc;
            end
        end
    end

    // Decoded straight from the state register so reset drops it immediately.
    assign res_valid = (r_state == S_RESP);
    assign res_taken = r_res_taken;
    assign res_pc    = r_res_pc;
    assign flags_out = r_flags;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_taken;
    logic [CNT_W-1:0] r_stat_not_taken;
    logic             w_res_hs;

    assign w_res_hs = res_valid && res_ready;

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_taken     <= '0;
            r_stat_not_taken <= '0;
        end else if (stat_clr) begin
            r_stat_taken     <= '0;
            r_stat_not_taken <= '0;
        end else if (w_res_hs) begin
            if (r_res_taken) begin
                if (r_stat_taken != {CNT_W{1'b1}}) begin
                    r_stat_taken <= r_stat_taken + 1'b1;
                end
            end else begin
                if (r_stat_not_taken != {CNT_W{1'b1}}) begin
                    r_stat_not_taken <= r_stat_not_taken + 1'b1;
                end
            end
        end
    end

    assign stat_taken     = r_stat_taken;
    assign stat_not_taken = r_stat_not_taken;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_cond_unit
//
// Directed testbench for branch_cond_unit. Each task drives one scenario and
// compares outputs against hand-computed values. With BRANCH_STATS_EN defined,
// a second instance with CNT_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_cond_unit;

    localparam int PC_W = 16;

    logic            clk;
    logic            rst;
    logic            flag_we;
    logic [3:0]      szcv_in;
    logic            flags_pending;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc_plus1;
    logic            res_valid;
    logic            res_ready;
    logic            res_taken;
    logic [PC_W-1:0] res_pc;
    logic [3:0]      flags_out;

    int n_vec = 0;
    int n_err = 0;

`ifdef BRANCH_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_taken;
    logic [15:0] stat_not_taken;
    logic        s_br_ready, s_res_valid, s_res_taken;
    logic [15:0] s_res_pc;
    logic [3:0]  s_flags_out;
    logic [1:0]  s_stat_taken;
    logic [1:0]  s_stat_not_taken;
`endif

    branch_cond_unit #(.PC_W(PC_W), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .flag_we       (flag_we),
        .szcv_in       (szcv_in),
        .flags_pending (flags_pending),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_cond       (br_cond),
        .br_target     (br_target),
        .pc_plus1      (pc_plus1),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_taken     (res_taken),
        .res_pc        (res_pc),
        .flags_out     (flags_out)
`ifdef BRANCH_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_taken    (stat_taken),
        .stat_not_taken(stat_not_taken)
`endif
    );

`ifdef BRANCH_STATS_EN
    branch_cond_unit #(.PC_W(PC_W), .CNT_W(2)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .flag_we       (flag_we),
        .szcv_in       (szcv_in),
        .flags_pending (flags_pending),
        .br_valid      (br_valid),
        .br_ready      (s_br_ready),
        .br_cond       (br_cond),
        .br_target     (br_target),
        .pc_plus1      (pc_plus1),
        .res_valid     (s_res_valid),
        .res_ready     (res_ready),
        .res_taken     (s_res_taken),
        .res_pc        (s_res_pc),
        .flags_out     (s_flags_out),
        .stat_clr      (stat_clr),
        .stat_taken    (s_stat_taken),
        .stat_not_taken(s_stat_not_taken)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        szcv_in = f;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] c, input logic [15:0] t, input logic [15:0] p);
        br_valid  = 1'b1;
        br_cond   = c;
        br_target = t;
        pc_plus1  = p;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", flags_out); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_vec++; if (res_taken !== 1'b0) begin n_err++; $display("FAIL rst_res_taken: got %b want 0", res_taken); end
        n_vec++; if (res_pc !== 16'h0000) begin n_err++; $display("FAIL rst_res_pc: got %h want 0000", res_pc); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_vec++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL idle_br_ready: got %b want 1", br_ready); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL idle_res_valid: got %b want 0", res_valid); end
    endtask

    task automatic test_be();
        set_flags(4'b0100);
        n_vec++; if (flags_out !== 4'b0100) begin n_err++; $display("FAIL be_flags: got %b want 0100", flags_out); end
        res_ready = 1'b1;
        drive_req(3'b000, 16'h0040, 16'h0011);
        #1;
        n_vec++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL be_br_ready: got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL be_res_valid: got %b want 1", res_valid); end
        n_vec++; if (res_taken !== 1'b1) begin n_err++; $display("FAIL be_res_taken: got %b want 1", res_taken); end
        n_vec++; if (res_pc !== 16'h0040) begin n_err++; $display("FAIL be_res_pc: got %h want 0040", res_pc); end
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL be_idle: got %b want 0", res_valid); end
    endtask

    task automatic test_wait();
        set_flags(4'b0000);
        flags_pending = 1'b1;
        res_ready     = 1'b1;
        drive_req(3'b001, 16'h0100, 16'h0021);
        tick();
        br_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL wait_br_ready[%0d]: got %b want 0", i, br_ready); end
            n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL wait_res_valid[%0d]: got %b want 0", i, res_valid); end
            tick();
        end
        flag_we = 1'b1;
        szcv_in = 4'b1000;
        tick();
        flag_we       = 1'b0;
        flags_pending = 1'b0;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL wait_res_valid: got %b want 1", res_valid); end
        n_vec++; if (res_taken !== 1'b1) begin n_err++; $display("FAIL wait_res_taken: got %b want 1", res_taken); end
        n_vec++; if (res_pc !== 16'h0100) begin n_err++; $display("FAIL wait_res_pc: got %h want 0100", res_pc); end
        n_vec++; if (flags_out !== 4'b1000) begin n_err++; $display("FAIL wait_flags: got %b want 1000", flags_out); end
        tick();
    endtask

    // Pending drops without a flag write: resolve with stored flags (Z=1).
    task automatic test_wait_drop();
        set_flags(4'b0100);
        flags_pending = 1'b1;
        res_ready     = 1'b1;
        drive_req(3'b000, 16'h0180, 16'h0029);
        tick();
        br_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL drop_wait: got %b want 0", res_valid); end
        flags_pending = 1'b0;
        tick();
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL drop_res_valid: got %b want 1", res_valid); end
        n_vec++; if (res_pc !== 16'h0180) begin n_err++; $display("FAIL drop_res_pc: got %h want 0180", res_pc); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_flags(4'b1000);
        res_ready = 1'b0;
        drive_req(3'b011, 16'h0200, 16'h0031);
        tick();
        // Next request is presented while stalled; it must be held off.
        drive_req(3'b100, 16'h0300, 16'h0041);
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, res_valid); end
            n_vec++; if (res_taken !== 1'b1) begin n_err++; $display("FAIL stall_taken[%0d]: got %b want 1", i, res_taken); end
            n_vec++; if (res_pc !== 16'h0200) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 0200", i, res_pc); end
            n_vec++; if (br_ready !== 1'b0) begin n_err++; $display("FAIL stall_br_ready[%0d]: got %b want 0", i, br_ready); end
            tick();
        end
        res_ready = 1'b1;
        #1;
        n_vec++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL b2b_br_ready: got %b want 1", br_ready); end
        tick();
        br_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", res_valid); end
        n_vec++; if (res_pc !== 16'h0300) begin n_err++; $display("FAIL b2b_pc: got %h want 0300", res_pc); end
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", res_valid); end
    endtask

    task automatic test_forward();
        set_flags(4'b0100);
        res_ready = 1'b1;
        flag_we   = 1'b1;
        szcv_in   = 4'b0000;
        drive_req(3'b010, 16'h0400, 16'h0051);
        tick();
        flag_we  = 1'b0;
        br_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL fwd_valid: got %b want 1", res_valid); end
        n_vec++; if (res_taken !== 1'b0) begin n_err++; $display("FAIL fwd_taken: got %b want 0", res_taken); end
        n_vec++; if (res_pc !== 16'h0051) begin n_err++; $display("FAIL fwd_pc: got %h want 0051", res_pc); end
        n_vec++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL fwd_flags: got %b want 0000", flags_out); end
        tick();
    endtask

    task automatic test_conditions();
        logic [3:0] tf [10];
        logic [2:0] tc [10];
        logic       te [10];
        logic [15:0] exp_pc;
        tf = '{4'b0001, 4'b1001, 4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tc = '{3'b001,  3'b001,  3'b010,  3'b011,  3'b101,  3'b110,  3'b110,  3'b111,  3'b100,  3'b000};
        te = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_flags(tf[i]);
            drive_req(tc[i], 16'h1000 + 16'(i), 16'h2000 + 16'(i));
            tick();
            br_valid = 1'b0;
            exp_pc = te[i] ? (16'h1000 + 16'(i)) : (16'h2000 + 16'(i));
            n_vec++; if (res_taken !== te[i]) begin n_err++; $display("FAIL cond[%0d] cc=%b f=%b taken: got %b want %b", i, tc[i], tf[i], res_taken, te[i]); end
            n_vec++; if (res_pc !== exp_pc) begin n_err++; $display("FAIL cond[%0d] pc: got %h want %h", i, res_pc, exp_pc); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        drive_req(3'b100, 16'h0500, 16'h0061);
        tick();
        br_valid = 1'b0;
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", res_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mid_res_valid: got %b want 0", res_valid); end
        n_vec++; if (res_pc !== 16'h0000) begin n_err++; $display("FAIL mid_res_pc: got %h want 0000", res_pc); end
        n_vec++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL mid_flags: got %b want 0000", flags_out); end
        @(negedge clk);
        rst       = 1'b0;
        res_ready = 1'b1;
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_valid: got %b want 0", res_valid); end
        n_vec++; if (br_ready !== 1'b1) begin n_err++; $display("FAIL mid_after_ready: got %b want 1", br_ready); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        res_ready = 1'b1;
        stat_clr  = 1'b1;
        tick();
        stat_clr = 1'b0;
        // 3 taken (B), 2 not-taken (reserved), back-to-back.
        for (int i = 0; i < 5; i++) begin
            drive_req((i < 3) ? 3'b100 : 3'b111, 16'h0600, 16'h0071);
            tick();
        end
        br_valid = 1'b0;
        tick();
        n_vec++; if (stat_taken !== 16'd3) begin n_err++; $display("FAIL stat_taken: got %0d want 3", stat_taken); end
        n_vec++; if (stat_not_taken !== 16'd2) begin n_err++; $display("FAIL stat_not_taken: got %0d want 2", stat_not_taken); end
        for (int i = 0; i < 2; i++) begin
            drive_req(3'b100, 16'h0600, 16'h0071);
            tick();
        end
        br_valid = 1'b0;
        tick();
        n_vec++; if (stat_taken !== 16'd5) begin n_err++; $display("FAIL stat_taken5: got %0d want 5", stat_taken); end
        n_vec++; if (s_stat_taken !== 2'd3) begin n_err++; $display("FAIL stat_sat: got %0d want 3", s_stat_taken); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_vec++; if (stat_taken !== 16'd0) begin n_err++; $display("FAIL stat_clr_t: got %0d want 0", stat_taken); end
        n_vec++; if (stat_not_taken !== 16'd0) begin n_err++; $display("FAIL stat_clr_nt: got %0d want 0", stat_not_taken); end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        flag_we       = 1'b0;
        szcv_in       = 4'b0000;
        flags_pending = 1'b0;
        br_valid      = 1'b0;
        br_cond       = 3'b000;
        br_target     = '0;
        pc_plus1      = '0;
        res_ready     = 1'b0;
`ifdef BRANCH_STATS_EN
        stat_clr      = 1'b0;
`endif
        test_reset();
        test_be();
        test_wait();
        test_wait_drop();
        test_back_to_back();
        test_forward();
        test_conditions();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
